y_mat_addr_fetch: RTL

Y_MAT_ADDR_FETCH -- requirements
Module: y_mat_addr_fetch

---
 rtl/y_mat_pkg.sv | 20 ++
 rtl/y_mat_slot_extract.sv | 26 ++
 rtl/y_mat_addr_fetch.sv | 129 ++++++++++++
 3 files changed

// File: rtl/y_mat_pkg.sv
// Shared types and default geometry for the Y-matrix row address fetcher.
package y_mat_pkg;

    localparam int Y_DATA_W    = 256;
    localparam int Y_ENTRY_W   = 16;
    localparam int Y_FIELD_W   = 10;
    localparam int Y_OUT_W     = 11;
    localparam int Y_ROW_W     = 16;
    localparam int Y_MEM_AW    = 10;
    localparam int Y_NUM_ROWS  = 256;
    localparam int Y_BASE_ADDR = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/y_mat_slot_extract.sv
// Selects one packed entry from a memory word (slot 0 = MSBs) and returns its
// low address field zero-extended to the output width.
module y_mat_slot_extract #(
    parameter int DATA_W  = 256,
    parameter int ENTRY_W = 16,
    parameter int FIELD_W = 10,
    parameter int OUT_W   = 11,
    parameter int SLOT_W  = 4
) (
    input  logic [DATA_W-1:0] word,
    input  logic [SLOT_W-1:0] slot,
    output logic [OUT_W-1:0]  field
);

    localparam int ENTRIES = DATA_W / ENTRY_W;
    localparam int LSB_W   = $clog2(DATA_W);

    logic [LSB_W-1:0] lsb;

    always_comb begin
        lsb   = LSB_W'((ENTRIES - 1 - int'(slot)) * ENTRY_W);
        field = '0;
        field[FIELD_W-1:0] = word[lsb +: FIELD_W];
    end

endmodule

// File: rtl/y_mat_addr_fetch.sv
// Row-to-address fetcher: maps a row to a packed entry in Y-matrix memory,
// with a single-word cache in front of the memory read port.
//
// state | meaning
// IDLE  | ready for a request; evaluates range and cache hit
// READ  | one-cycle memory read strobe
// WAIT  | waiting for read data; fills the cache
// DONE  | result presented until the consumer accepts it
module y_mat_addr_fetch
    import y_mat_pkg::*;
#(
    parameter int DATA_W    = Y_DATA_W,
    parameter int ENTRY_W   = Y_ENTRY_W,
    parameter int FIELD_W   = Y_FIELD_W,
    parameter int OUT_W     = Y_OUT_W,
    parameter int ROW_W     = Y_ROW_W,
    parameter int MEM_AW    = Y_MEM_AW,
    parameter int NUM_ROWS  = Y_NUM_ROWS,
    parameter int BASE_ADDR = Y_BASE_ADDR
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ROW_W-1:0]  req_row,
    output logic              req_ready,
    output logic              mem_rd_en,
    output logic [MEM_AW-1:0] mem_rd_addr,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              inv,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_addr,
    output logic              out_err,
    input  logic              out_ready
);

    localparam int ENTRIES = DATA_W / ENTRY_W;
    localparam int SLOT_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    state_t              state;
    logic                cache_valid;
    logic [MEM_AW-1:0]   cache_addr;
    logic [DATA_W-1:0]   cache_data;
    logic [SLOT_W-1:0]   slot_q;
    logic                err_q;

    logic [MEM_AW-1:0]   req_waddr;
    logic [SLOT_W-1:0]   req_slot;
    logic                req_oor;
    logic                req_hit;
    logic [DATA_W-1:0]   sel_word;
    logic [SLOT_W-1:0]   sel_slot;
    logic [OUT_W-1:0]    field;

    assign req_waddr = MEM_AW'(BASE_ADDR + (32'(req_row) / ENTRIES));
    assign req_slot  = SLOT_W'(32'(req_row) % ENTRIES);
    assign req_oor   = 32'(req_row) >= NUM_ROWS;
    // An invalidate landing on the acceptance cycle forces a miss.
    assign req_hit   = cache_valid && !inv && (cache_addr == req_waddr);

    // During a fill the result comes straight from the returned word.
    assign sel_word = (state == ST_WAIT) ? mem_rd_data : cache_data;
    assign sel_slot = (state == ST_WAIT) ? slot_q : req_slot;

    y_mat_slot_extract #(
        .DATA_W  (DATA_W),
        .ENTRY_W (ENTRY_W),
        .FIELD_W (FIELD_W),
        .OUT_W   (OUT_W),
        .SLOT_W  (SLOT_W)
    ) u_extract (
        .word  (sel_word),
        .slot  (sel_slot),
        .field (field)
    );

    assign req_ready = (state == ST_IDLE);
    assign mem_rd_en = (state == ST_READ);
    assign out_valid = (state == ST_DONE);
    assign out_err   = (state == ST_DONE) && err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            cache_valid <= 1'b0;
            cache_addr  <= '0;
            cache_data  <= '0;
            slot_q      <= '0;
            err_q       <= 1'b0;
            mem_rd_addr <= '0;
            out_addr    <= '0;
        end else begin
            if (inv) cache_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        slot_q      <= req_slot;
                        mem_rd_addr <= req_waddr;
                        if (req_oor) begin
                            err_q    <= 1'b1;
                            out_addr <= '0;
                            state    <= ST_DONE;
                        end else if (req_hit) begin
                            err_q    <= 1'b0;
                            out_addr <= field;
                            state    <= ST_DONE;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                ST_READ: state <= ST_WAIT;
                ST_WAIT: begin
                    if (mem_rd_valid) begin
                        cache_data  <= mem_rd_data;
                        cache_addr  <= mem_rd_addr;
                        cache_valid <= !inv;
                        err_q       <= 1'b0;
                        out_addr    <= field;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: if (out_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
